// File: rtl/mem_resp_if.sv
// CPU <-> memory responder bus.
//   memaddr/wdata/read/write : driven by the CPU (master)
//   rdata/ready/busy         : driven by the responder (slave)
//   addr_err                 : only present when MEM_BOUND_CHECK_EN is defined
interface mem_resp_if;
  logic [15:0] memaddr;
  logic [7:0]  wdata;
  logic        read;
  logic        write;
  logic [7:0]  rdata;
  logic        ready;
  logic        busy;
`ifdef MEM_BOUND_CHECK_EN
  logic        addr_err;
`endif

  modport master (
    output memaddr, wdata, read, write,
`ifdef MEM_BOUND_CHECK_EN
    input  addr_err,
`endif
    input  rdata, ready, busy
  );

  modport slave (
    input  memaddr, wdata, read, write,
`ifdef MEM_BOUND_CHECK_EN
    output addr_err,
`endif
    output rdata, ready, busy
  );
endinterface

// File: rtl/mem_resp.sv
// Memory-side responder for the CPU external memory bus.
// Holds an 8-bit-wide store of 2**ADDR_W bytes, answers CPU reads/writes with a
// one-cycle ready pulse WAIT_CYCLES+1 edges after the request edge, and exposes
// a loader port for preloading the store while the CPU is held off.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   bus      CPU bus (slave side): memaddr, wdata, read, write -> rdata, ready, busy
//   ld_en    loader mode, blocks CPU requests in IDLE
//   ld_we    loader write strobe (only honoured with ld_en in IDLE)
//   ld_addr  loader address
//   ld_data  loader data
//
// Optional feature (define MEM_BOUND_CHECK_EN): bus.addr_err output; requests
// with memaddr[15:ADDR_W] != 0 keep normal timing but skip the array, reads
// return 8'hFF and addr_err pulses with ready. Without it upper bits alias.
module mem_resp #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_resp_if.slave         bus,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              wr_q;
  logic              oob_q;
  logic [7:0]        rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              addr_err_q;

  logic [7:0] mem [2**ADDR_W];

  // Out-of-range detection on the live address.
  logic oob_in;
`ifdef MEM_BOUND_CHECK_EN
  assign oob_in = |bus.memaddr[15:ADDR_W];
`else
  assign oob_in = 1'b0;
  logic unused_hi;
  assign unused_hi = ^bus.memaddr[15:ADDR_W];
`endif

  logic req;
  assign req = (state == IDLE) && !ld_en && (bus.read || bus.write);

  // The access commits on the edge that enters DONE: either straight from IDLE
  // (zero wait states, using live inputs) or from BUSY when the counter expires
  // (using latched values).
  logic              commit_idle, commit_busy, commit;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_data;
  logic              c_wr, c_oob;

  assign commit_idle = req && (WAIT_CYCLES == 0);
  assign commit_busy = (state == BUSY) && (cnt == 4'd1);
  assign commit      = commit_idle || commit_busy;
  assign c_addr      = commit_idle ? bus.memaddr[ADDR_W-1:0] : addr_q;
  assign c_data      = commit_idle ? bus.wdata : data_q;
  assign c_wr        = commit_idle ? (!bus.read && bus.write) : wr_q;
  assign c_oob       = commit_idle ? oob_in : oob_q;

  // CPU and loader writes never coincide: the CPU commit from IDLE needs
  // ld_en=0, and loader writes are held off outside IDLE.
  logic cpu_we, ldr_we;
  assign cpu_we = commit && c_wr && !c_oob;
  assign ldr_we = (state == IDLE) && ld_en && ld_we;

  // Store is intentionally not reset.
  always_ff @(posedge clk) begin
    if (cpu_we)      mem[c_addr]  <= c_data;
    else if (ldr_we) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      oob_q      <= 1'b0;
      rdata_q    <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      if (commit && !c_wr) rdata_q <= c_oob ? 8'hFF : mem[c_addr];
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= bus.memaddr[ADDR_W-1:0];
            data_q <= bus.wdata;
            wr_q   <= !bus.read && bus.write;  // read wins
            oob_q  <= oob_in;
            busy_q <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state      <= DONE;
              ready_q    <= 1'b1;
              addr_err_q <= oob_in;
            end else begin
              state <= BUSY;
              cnt   <= WAIT_INIT;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= DONE;
            ready_q    <= 1'b1;
            addr_err_q <= oob_q;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
`ifdef MEM_BOUND_CHECK_EN
  assign bus.addr_err = addr_err_q;
`else
  logic unused_err;
  assign unused_err = addr_err_q;
`endif

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the CPU's external memory interface. It accepts the CPU's read/write strobes, address and write data, and returns read data plus a one-cycle ready pulse after a programmable number of wait states.
- Holds the program/data store as an internal 8-bit-wide array.
- A loader port lets the front panel/switch logic preload the store while the CPU is held off.

Parameters:
- ADDR_W, 8, number of low address bits decoded; depth = 2**ADDR_W bytes.
- WAIT_CYCLES, 1, extra cycles between request sample and ready; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active low.
- memaddr  input  16  CPU address.
- wdata  input  8  CPU write data (CPU data_out).
- read  input  1  CPU read strobe, level.
- write  input  1  CPU write strobe, level.
- rdata  output  8  read data to CPU (CPU data_in), registered.
- ready  output  1  one-cycle completion pulse, registered.
- busy  output  1  high in BUSY or DONE.
- ld_en  input  1  loader mode; blocks CPU requests.
- ld_we  input  1  loader write strobe.
- ld_addr  input  ADDR_W  loader address.
- ld_data  input  8  loader data.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active low.
- Reset (rst=0): state=IDLE, ready=0, busy=0, rdata=8'h00, wait counter=0, latched op/addr/data cleared.
- Memory contents are not reset. A reset mid-access aborts the access; an uncommitted write is never performed.
- FSM states: IDLE, BUSY, DONE.
- IDLE, with ld_en=0 and (read|write)=1 at a clk edge:
  - latch memaddr[ADDR_W-1:0], wdata and op;
  - read has priority, so read&write together is treated as a read and the write is dropped;
  - go to BUSY with counter=WAIT_CYCLES, or straight to DONE if WAIT_CYCLES=0.
- BUSY: counter decrements each cycle; at 1, go to DONE.
- Entry to DONE:
  - read: rdata <= mem[addr];
  - write: mem[addr] <= wdata.
- DONE: ready=1 for exactly that cycle, then return to IDLE.
- Latency: request sampled at edge N gives ready high during cycle N+1+WAIT_CYCLES.
- rdata holds its value until the next read completes. Writes and loader writes do not change rdata.
- Strobes are level-sensitive. Changes during BUSY/DONE are ignored. If a strobe is still high in IDLE after DONE, a new access starts, so the CPU deasserts it by the ready cycle.
- busy=1 in BUSY and DONE, 0 in IDLE.
- Loader:
  - ld_en=1 forces CPU requests to be ignored in IDLE;
  - ld_en=1 with ld_we=1 writes mem[ld_addr] <= ld_data at the edge, single cycle, back-to-back allowed;
  - ld_we is ignored when ld_en=0;
  - ld_en asserted during BUSY/DONE does not abort the in-flight access, and loader writes are held off until IDLE.
- Address handling: memaddr[15:ADDR_W] is ignored (aliasing) unless the optional feature is enabled. Address 2**ADDR_W-1 is valid; there is no wrap logic beyond truncation.

Optional Feature:
- Macro: MEM_BOUND_CHECK_EN.
- Enabled:
  - adds output addr_err (1 bit, reset 0);
  - a request with memaddr[15:ADDR_W]!=0 follows the same FSM timing but performs no array access;
  - a read loads rdata=8'hFF;
  - addr_err pulses in the same cycle as ready.
- Disabled: no addr_err port; upper address bits alias into the array.

Test Plan:
- Reset then idle: rst low for 3 cycles → rdata=8'h00, ready=0, busy=0; no ready pulse with strobes low.
- Loader then read (WAIT_CYCLES=1):
  - stimulus: ld_en=1, ld_we=1, ld_addr=8'h10, ld_data=8'hA5; then ld_en=0; read=1, memaddr=16'h0010 sampled at edge N;
  - response: ready high in cycle N+2, rdata=8'hA5, rdata held after read drops.
- Write/read-back:
  - stimulus: write=1, memaddr=16'h0020, wdata=8'h3C, then read of 16'h0020;
  - response: ready for each access 2 cycles after sample; rdata=8'h3C; rdata unchanged by the write.
- Simultaneous read&write:
  - stimulus: mem[8'h30]=8'h11; read=write=1 at 16'h0030 with wdata=8'h99;
  - response: rdata=8'h11; a later read returns 8'h11.
- Reset mid-write: assert rst during BUSY of a write of 8'h77 to 8'h40 where mem=8'h00 → later read returns 8'h00; ready never pulses for the aborted access.
- MEM_BOUND_CHECK_EN:
  - read at 16'h0110 → ready and addr_err pulse together, rdata=8'hFF;
  - write at 16'h0110 → mem[8'h10] unchanged.
